// File: rtl/vx_gbar_multi_unit_if.sv
// Request/release handshake bundle between the gbar arbiter and the multi-barrier unit.
// The master drives arrivals and consumes releases; the slave is the barrier unit.
interface vx_gbar_multi_unit_if #(
   parameter int NUM_BARRIERS = 8,
   parameter int NUM_CORES    = 16
);
   localparam int IDW = $clog2(NUM_BARRIERS);
   localparam int CW  = $clog2(NUM_CORES);

   logic           req_valid;
   logic [IDW-1:0] req_id;
   logic [CW-1:0]  req_size_m1;
   logic [CW-1:0]  req_core_id;
   logic           req_ready;
   logic           rsp_valid;
   logic [IDW-1:0] rsp_id;
   logic           rsp_ready;

   modport master (
      output req_valid, req_id, req_size_m1, req_core_id, rsp_ready,
      input  req_ready, rsp_valid, rsp_id
   );

   modport slave (
      input  req_valid, req_id, req_size_m1, req_core_id, rsp_ready,
      output req_ready, rsp_valid, rsp_id
   );
endinterface

// File: rtl/vx_gbar_multi_unit.sv
// Cluster global barrier unit: per-ID arrival masks, protocol error detection and a
// FIFO of pending release broadcasts with backpressure.
module vx_gbar_multi_unit #(
   parameter int NUM_BARRIERS = 8,
   parameter int NUM_CORES    = 16,
   parameter int RSP_QUEUE    = 4,
   parameter     INSTANCE_ID  = ""
) (
   input  logic                 clk,
   input  logic                 reset,
   vx_gbar_multi_unit_if.slave  bus,
   output logic                 error,
   output logic                 busy
);
   localparam int IDW = $clog2(NUM_BARRIERS);
   localparam int CW  = $clog2(NUM_CORES);
   localparam int QW  = $clog2(RSP_QUEUE);

   function automatic logic [CW:0] popcount(input logic [NUM_CORES-1:0] v);
      logic [CW:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         cnt = cnt + {{CW{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_vec;
   logic [NUM_BARRIERS-1:0][CW-1:0]        size_vec;

   logic [NUM_CORES-1:0] cur_mask;
   logic [CW-1:0]        cur_size;
   logic [NUM_CORES-1:0] new_mask;
   logic [CW-1:0]        eff_size;
   logic                 accept;
   logic                 dup;
   logic                 first;
   logic                 mismatch;
   logic                 complete;
   logic                 update;
   logic                 push;
   logic                 pop;

   logic [IDW-1:0] q_mem_q [RSP_QUEUE];
   logic [QW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [QW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [QW:0]    count_q, count_d;
   logic           error_q, error_d;
   logic           q_full;
   logic           q_empty;

   assign q_full  = (count_q == (QW+1)'(RSP_QUEUE));
   assign q_empty = (count_q == '0);

   // Ready comes from registered occupancy only, so a same-cycle pop never opens it.
   assign bus.req_ready = !q_full;
   assign bus.rsp_valid = !q_empty;
   assign bus.rsp_id    = q_empty ? '0 : q_mem_q[rd_ptr_q];

   assign accept   = bus.req_valid && bus.req_ready;
   assign pop      = bus.rsp_valid && bus.rsp_ready;
   assign cur_mask = mask_vec[bus.req_id];
   assign cur_size = size_vec[bus.req_id];
   assign dup      = cur_mask[bus.req_core_id];
   assign first    = (cur_mask == '0);
   assign eff_size = first ? bus.req_size_m1 : cur_size;
   assign mismatch = !first && (bus.req_size_m1 != cur_size);
   assign new_mask = cur_mask | (NUM_CORES'(1) << bus.req_core_id);
   // size+1 fits in CW+1 bits, so the comparison cannot overflow.
   assign complete = (popcount(new_mask) == ({1'b0, eff_size} + (CW+1)'(1)));
   assign update   = accept && !dup;
   assign push     = update && complete;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
         logic [NUM_CORES-1:0] mask_q, mask_d;
         logic [CW-1:0]        size_q, size_d;

         always_comb begin
            mask_d = mask_q;
            size_d = size_q;
            if (update && (bus.req_id == IDW'(gi))) begin
               if (first) begin
                  size_d = bus.req_size_m1;
               end
               mask_d = complete ? '0 : new_mask;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               mask_q <= '0;
               size_q <= '0;
            end else begin
               mask_q <= mask_d;
               size_q <= size_d;
            end
         end

         assign mask_vec[gi] = mask_q;
         assign size_vec[gi] = size_q;
      end
   endgenerate

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      error_d  = error_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + QW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + QW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (QW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (QW+1)'(1);
      end
      if (accept && (dup || mismatch)) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         error_q  <= error_d;
      end
   end

   // Queue storage needs no reset: entries are only visible behind count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         q_mem_q[wr_ptr_q] <= bus.req_id;
      end
   end

   assign error = error_q;
   assign busy  = (|mask_vec) || !q_empty;

`ifdef VX_GBAR_TRACE
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         $display("%s gbar arrival id=%0d core=%0d size_m1=%0d", INSTANCE_ID,
                  bus.req_id, bus.req_core_id, bus.req_size_m1);
         if (dup || mismatch) begin
            $display("%s gbar protocol error id=%0d core=%0d dup=%0b size=%0b", INSTANCE_ID,
                     bus.req_id, bus.req_core_id, dup, mismatch);
         end
         if (push) begin
            $display("%s gbar release id=%0d", INSTANCE_ID, bus.req_id);
         end
      end
   end
`endif

endmodule

// File: tb/tb_vx_gbar_multi_unit.sv
// Directed bench for vx_gbar_multi_unit: expected release IDs are queued as each
// completing arrival is driven and popped by a monitor on every release handshake.
module tb_vx_gbar_multi_unit;
   logic clk;
   logic reset;
   logic error;
   logic busy;

   int n_checks;
   int n_errors;
   int sb[$];

   vx_gbar_multi_unit_if #(.NUM_BARRIERS(8), .NUM_CORES(16)) bus ();

   vx_gbar_multi_unit #(
      .NUM_BARRIERS(8),
      .NUM_CORES(16),
      .RSP_QUEUE(4),
      .INSTANCE_ID("gbar0")
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .error(error),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic arrive(input int id, input int sz, input int core, input bit rel);
      bus.req_valid   = 1'b1;
      bus.req_id      = 3'(id);
      bus.req_size_m1 = 4'(sz);
      bus.req_core_id = 4'(core);
      chk($sformatf("req_ready id=%0d core=%0d", id, core), 32'(bus.req_ready), 32'd1);
      if (rel) sb.push_back(id);
      cyc();
      bus.req_valid = 1'b0;
      $display("arrive id=%0d size_m1=%0d core=%0d release_expected=%0b rsp_valid=%0b busy=%0b error=%0b",
               id, sz, core, rel, bus.rsp_valid, busy, error);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      sb.delete();
   endtask

   // Release monitor: a handshake visible at the falling edge completes at the next rise.
   always @(negedge clk) begin
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         n_checks++;
         assert (sb.size() > 0) else begin
            n_errors++;
            $error("FAIL rsp_unexpected observed=%0d expected=none", bus.rsp_id);
         end
         if (sb.size() > 0) begin
            automatic int exp_id = sb.pop_front();
            $display("release rsp_id=%0d expected=%0d", bus.rsp_id, exp_id);
            n_checks++;
            assert (32'(bus.rsp_id) === 32'(exp_id)) else begin
               n_errors++;
               $error("FAIL rsp_id observed=%0d expected=%0d", bus.rsp_id, exp_id);
            end
         end
      end
   end

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      reset           = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_id      = '0;
      bus.req_size_m1 = '0;
      bus.req_core_id = '0;
      bus.rsp_ready   = 1'b1;
      cyc();
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

      // 4-core barrier on id 3
      arrive(3, 3, 0, 0);
      chk("t1_valid_c0", 32'(bus.rsp_valid), 32'd0);
      chk("t1_busy_c0", 32'(busy), 32'd1);
      arrive(3, 3, 1, 0);
      chk("t1_valid_c1", 32'(bus.rsp_valid), 32'd0);
      arrive(3, 3, 2, 0);
      chk("t1_valid_c2", 32'(bus.rsp_valid), 32'd0);
      arrive(3, 3, 5, 1);
      chk("t1_valid_c5", 32'(bus.rsp_valid), 32'd1);
      chk("t1_id_c5", 32'(bus.rsp_id), 32'd3);
      chk("t1_busy_c5", 32'(busy), 32'd1);
      cyc();
      chk("t1_valid_after", 32'(bus.rsp_valid), 32'd0);
      chk("t1_busy_after", 32'(busy), 32'd0);

      // interleaved barriers 1 and 6
      arrive(1, 1, 2, 0);
      arrive(6, 2, 0, 0);
      arrive(6, 2, 1, 0);
      chk("t2_valid_mid", 32'(bus.rsp_valid), 32'd0);
      arrive(1, 1, 7, 1);
      chk("t2_id1", 32'(bus.rsp_id), 32'd1);
      arrive(6, 2, 3, 1);
      chk("t2_id6", 32'(bus.rsp_id), 32'd6);
      cyc();
      chk("t2_error", 32'(error), 32'd0);
      chk("t2_busy", 32'(busy), 32'd0);

      // fill the release queue under backpressure
      bus.rsp_ready = 1'b0;
      arrive(0, 0, 0, 1);
      chk("t3_latency", 32'(bus.rsp_valid), 32'd1);
      arrive(1, 0, 0, 1);
      arrive(2, 0, 0, 1);
      arrive(3, 0, 0, 1);
      chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid   = 1'b1;
      bus.req_id      = 3'd4;
      bus.req_size_m1 = 4'd0;
      bus.req_core_id = 4'd0;
      sb.push_back(4);
      cyc();
      chk("t3_stall_ready0", 32'(bus.req_ready), 32'd0);
      chk("t3_stall_id0", 32'(bus.rsp_id), 32'd0);
      cyc();
      chk("t3_stall_ready1", 32'(bus.req_ready), 32'd0);
      chk("t3_stall_id1", 32'(bus.rsp_id), 32'd0);
      bus.rsp_ready = 1'b1;
      cyc();
      chk("t3_ready_after_pop", 32'(bus.req_ready), 32'd1);
      chk("t3_id_after_pop", 32'(bus.rsp_id), 32'd1);
      cyc();
      bus.req_valid = 1'b0;
      chk("t3_id_next", 32'(bus.rsp_id), 32'd2);
      cyc();
      cyc();
      cyc();
      cyc();
      chk("t3_drained", 32'(bus.rsp_valid), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);

      // duplicate arrival
      arrive(2, 1, 4, 0);
      arrive(2, 1, 4, 0);
      chk("t4_error", 32'(error), 32'd1);
      chk("t4_no_release", 32'(bus.rsp_valid), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      arrive(2, 1, 9, 1);
      chk("t4_release", 32'(bus.rsp_valid), 32'd1);
      chk("t4_id", 32'(bus.rsp_id), 32'd2);
      cyc();
      chk("t4_error_sticky", 32'(error), 32'd1);

      // size mismatch keeps the latched size
      do_reset();
      chk("t5_error_cleared", 32'(error), 32'd0);
      arrive(5, 2, 0, 0);
      arrive(5, 1, 1, 0);
      chk("t5_error", 32'(error), 32'd1);
      chk("t5_no_release", 32'(bus.rsp_valid), 32'd0);
      arrive(5, 1, 2, 1);
      chk("t5_release", 32'(bus.rsp_valid), 32'd1);
      chk("t5_id", 32'(bus.rsp_id), 32'd5);
      cyc();

      // reset mid-operation
      do_reset();
      bus.rsp_ready = 1'b0;
      arrive(0, 0, 0, 1);
      arrive(1, 0, 0, 1);
      arrive(4, 3, 0, 0);
      arrive(7, 1, 5, 0);
      arrive(7, 1, 5, 0);
      chk("t6_pre_error", 32'(error), 32'd1);
      chk("t6_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      sb.delete();
      cyc();
      reset = 1'b0;
      chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t6_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_error", 32'(error), 32'd0);
      bus.rsp_ready = 1'b1;
      arrive(4, 0, 2, 1);
      chk("t6_fresh_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t6_fresh_id", 32'(bus.rsp_id), 32'd4);
      cyc();
      chk("t6_final_busy", 32'(busy), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/vx_gbar_multi_unit.md
Name: vx_gbar_multi_unit

Overview:
Cluster-level global barrier unit that tracks up to NUM_BARRIERS concurrent barriers across NUM_CORES cores.
- Successor to the single-barrier, no-backpressure gbar unit: adds per-core arrival masks, duplicate/mismatch error detection, a release queue and response backpressure.
- Sits behind the per-socket gbar arbiter. Its release broadcast returns to all sockets.

Parameters:
NUM_BARRIERS, 8, number of independent barrier IDs (power of 2, >=2)
NUM_CORES, 16, total cores in the cluster (power of 2, >=2)
RSP_QUEUE, 4, release queue depth (power of 2, >=2)
INSTANCE_ID, "", debug/trace name string

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  barrier arrival request
req_id  in  log2(NUM_BARRIERS)  barrier ID
req_size_m1  in  log2(NUM_CORES)  participating cores minus one
req_core_id  in  log2(NUM_CORES)  arriving core
req_ready  out  1  request accepted when valid&&ready
rsp_valid  out  1  release broadcast valid
rsp_id  out  log2(NUM_BARRIERS)  released barrier ID
rsp_ready  in  1  release consumed when valid&&ready
error  out  1  sticky protocol-error flag
busy  out  1  any barrier pending or release queued

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - all arrival masks = 0; all size registers = 0.
  - release queue empty, so rsp_valid=0 and rsp_id=0.
  - error=0, busy=0, req_ready=1.
  - Reset mid-operation discards all partial barriers and queued releases, with no response.
- Per-barrier state: mask[NUM_CORES] and size[log2(NUM_CORES)].
- req_ready = !queue_full. It uses registered occupancy; a pop in the same cycle does not raise ready.
- On accept, with b = req_id and c = req_core_id:
  - Duplicate arrival (mask[b][c] already 1): set error, drop the request, state unchanged.
  - First arrival (mask[b]==0): latch size[b] = req_size_m1.
  - Later arrival with req_size_m1 != size[b]: set error and keep the latched size. The arrival still counts.
  - Compute new_mask = mask[b] | (1<<c).
  - If popcount(new_mask) == size[b]+1, using the freshly latched value on a first arrival: clear mask[b] to 0 and push b into the release queue.
  - Otherwise write mask[b] = new_mask.
- Width rule: the popcount is log2(NUM_CORES)+1 bits, compared against a zero-extended size+1. No overflow is possible.
- size_m1=0: the first arrival releases immediately.
- Latency: a completing request accepted in cycle N gives rsp_valid=1 with rsp_id=b in cycle N+1 when the queue was empty. Otherwise the release appears in FIFO order.
- Release queue:
  - FIFO, depth RSP_QUEUE.
  - rsp_valid = !empty; rsp_id = head entry.
  - rsp_id is held stable while rsp_valid && !rsp_ready.
  - Pops on valid&&ready.
  - Simultaneous push and pop: occupancy unchanged, ordering preserved.
- The same barrier ID may be re-armed and released again while its earlier release is still queued. Both entries are delivered.
- Barriers are independent. An arrival on one ID never alters another ID's mask.
- busy = (|all masks) || !empty, driven combinationally from registers.
- error clears only on reset.
- Non-synthesis trace (INSTANCE_ID prefix) on each arrival, release and error.

Test Plan:
- 4-core barrier: reset, then arrivals id=3 size_m1=3 cores 0,1,2,5 on consecutive cycles with rsp_ready=1 -> rsp_valid only on the cycle after core 5, rsp_id=3; busy 1 from first arrival until the release pops, then 0.
- Interleave id=1 (size_m1=1, cores 2,7) with id=6 (size_m1=2, cores 0,1,3) -> releases in order id=1 then id=6; no cross-talk between masks; error=0.
- Hold rsp_ready=0 and complete 4 single-core barriers (size_m1=0, ids 0..3) -> queue full, req_ready=0, next request stalls; raise rsp_ready -> ids 0,1,2,3 in order, rsp_id stable while stalled.
- Core 4 arrives twice on id=2 (size_m1=1) -> error=1 after the second; the barrier still needs one more core; core 9 arrives -> release id=2.
- Size mismatch: id=5 arrivals with size_m1=2 then size_m1=1 -> error=1; release only after a third distinct core arrives.
- Assert reset with 2 partial barriers and 2 queued releases -> next cycle rsp_valid=0, busy=0, error=0; a fresh 1-core barrier releases normally.
